// File: rtl/bidir_sr_pkg.sv
// Shared types and constants for the bidirectional shift-register sequencer.
package bidir_sr_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CLEAR   = 3'd1,
    ST_LOAD    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/bidir_sr_ctrl.sv
// Sequencer that loads a parallel word into an external free-running
// bidirectional shift register one bit per clock, then snapshots the result.
// Optional feature macro: BIDIR_SR_CTRL_VERIFY_EN (adds snapshot-vs-request compare on rsp_err).
module bidir_sr_ctrl
  import bidir_sr_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_word,
  input  logic             req_dir,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_word,
  output logic             rsp_err,
  output logic             sr_reset,
  output logic             sr_shift,
  output logic             sr_data_in,
  input  logic [WIDTH-1:0] sr_data_out
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               dir_q, dir_d;
  logic               req_ready_q, req_ready_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]   rsp_word_q, rsp_word_d;
  logic               sr_reset_q, sr_reset_d;
  logic               sr_shift_q, sr_shift_d;
  logic               sr_data_in_q, sr_data_in_d;
  logic [CNT_W-1:0]   bit_idx_d;

  // Next-state, datapath and next-output decode; outputs are derived from the
  // next state so the registered copies line up with the state they belong to.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    word_d     = word_q;
    dir_d      = dir_q;
    rsp_word_d = rsp_word_q;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          word_d  = req_word;
          dir_d   = req_dir;
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        bit_cnt_d = '0;
        state_d   = ST_LOAD;
      end
      ST_LOAD: begin
        if (bit_cnt_q == CNT_LAST) begin
          bit_cnt_d = '0;
          state_d   = ST_CAPTURE;
        end else begin
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        rsp_word_d = sr_data_out;
        state_d    = ST_DONE;
      end
      ST_DONE: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // MSB first for left shifts, LSB first for right shifts
    bit_idx_d    = (dir_d == DIR_LEFT) ? (CNT_LAST - bit_cnt_d) : bit_cnt_d;

    req_ready_d  = (state_d == ST_IDLE);
    rsp_valid_d  = (state_d == ST_DONE);
    sr_reset_d   = (state_d == ST_CLEAR);
    sr_shift_d   = (state_d == ST_LOAD) ? dir_d : 1'b0;
    sr_data_in_d = (state_d == ST_LOAD) ? word_d[bit_idx_d] : 1'b0;
  end

  // State, datapath and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      word_q       <= '0;
      dir_q        <= DIR_LEFT;
      req_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_word_q   <= '0;
      sr_reset_q   <= 1'b0;
      sr_shift_q   <= 1'b0;
      sr_data_in_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      word_q       <= word_d;
      dir_q        <= dir_d;
      req_ready_q  <= req_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_word_q   <= rsp_word_d;
      sr_reset_q   <= sr_reset_d;
      sr_shift_q   <= sr_shift_d;
      sr_data_in_q <= sr_data_in_d;
    end
  end

`ifdef BIDIR_SR_CTRL_VERIFY_EN
  logic rsp_err_q, rsp_err_d;

  // Snapshot compare, captured alongside rsp_word and held through DONE
  always_comb begin
    rsp_err_d = rsp_err_q;
    if (state_q == ST_CAPTURE) rsp_err_d = (sr_data_out != word_q);
  end

  // Error flag register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rsp_err_q <= 1'b0;
    else       rsp_err_q <= rsp_err_d;
  end

  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_word   = rsp_word_q;
  assign sr_reset   = sr_reset_q;
  assign sr_shift   = sr_shift_q;
  assign sr_data_in = sr_data_in_q;

endmodule

// File: tb/tb_bidir_sr_ctrl.sv
// Directed bench for bidir_sr_ctrl with a behavioural 4-bit shift register beside it.
module tb_bidir_sr_ctrl;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic [W-1:0] req_word;
  logic         req_dir;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_word;
  logic         rsp_err;
  logic         sr_reset;
  logic         sr_shift;
  logic         sr_data_in;
  logic [W-1:0] sr_data_out;
  logic [W-1:0] sr_q;
  logic         force_zero;

  int n_cmp;
  int n_bad;

`ifdef BIDIR_SR_CTRL_VERIFY_EN
  localparam logic EXP_FORCED_ERR = 1'b1;
`else
  localparam logic EXP_FORCED_ERR = 1'b0;
`endif

  bidir_sr_ctrl #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_word    (req_word),
    .req_dir     (req_dir),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_word    (rsp_word),
    .rsp_err     (rsp_err),
    .sr_reset    (sr_reset),
    .sr_shift    (sr_shift),
    .sr_data_in  (sr_data_in),
    .sr_data_out (sr_data_out)
  );

  // Free-running shift register: shifts on every edge, sync clear on sr_reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset)              sr_q <= '0;
    else if (sr_reset)      sr_q <= '0;
    else if (sr_shift == 0) sr_q <= {sr_q[W-2:0], sr_data_in};
    else                    sr_q <= {sr_data_in, sr_q[W-1:1]};
  end

  assign sr_data_out = force_zero ? '0 : sr_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One request: checks CLEAR, the LOAD bit stream, latency, snapshot and the DONE stall
  task automatic run_req(input string tag, input logic [W-1:0] w, input logic d,
                         input logic [W-1:0] seq, input logic [W-1:0] exp_word,
                         input logic exp_err, input bit zap, input int stall);
    req_word  = w;
    req_dir   = d;
    req_valid = 1'b1;
    chk({tag, "_ready_before"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    chk({tag, "_clear_sr_reset"}, 32'(sr_reset), 32'd1);
    chk({tag, "_clear_ready"}, 32'(req_ready), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("%s_load%0d_din", tag, i), 32'(sr_data_in), 32'(seq[3-i]));
      chk($sformatf("%s_load%0d_shift", tag, i), 32'(sr_shift), 32'(d));
      chk($sformatf("%s_load%0d_sr_reset", tag, i), 32'(sr_reset), 32'd0);
    end
    tick();
    if (zap) force_zero = 1'b1;
    chk({tag, "_capture_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_capture_din"}, 32'(sr_data_in), 32'd0);
    tick();
    force_zero = 1'b0;
    chk({tag, "_rsp_valid_at6"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rsp_word"}, 32'(rsp_word), 32'(exp_word));
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'(exp_err));
    for (int s = 0; s < stall; s++) begin
      tick();
      chk($sformatf("%s_stall%0d_valid", tag, s), 32'(rsp_valid), 32'd1);
      chk($sformatf("%s_stall%0d_word", tag, s), 32'(rsp_word), 32'(exp_word));
      chk($sformatf("%s_stall%0d_ready", tag, s), 32'(req_ready), 32'd0);
      chk($sformatf("%s_stall%0d_sr", tag, s), 32'({sr_reset, sr_shift, sr_data_in}), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
  endtask

  int            acc_t [2];
  int            rsp_t [2];
  logic [W-1:0]  rsp_w [2];
  int            n_acc;
  int            n_rsp;
  logic          acc_now;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_word   = '0;
    req_dir    = 1'b0;
    rsp_ready  = 1'b0;
    force_zero = 1'b0;

    // Reset state
    tick(); tick(); tick();
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_word", 32'(rsp_word), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_sr_outs", 32'({sr_reset, sr_shift, sr_data_in}), 32'd0);
    reset = 1'b0;
    tick();
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // Basic loads in both directions
    run_req("r1000_left", 4'b1000, 1'b0, 4'b1000, 4'b1000, 1'b0, 1'b0, 0);
    run_req("r1011_right", 4'b1011, 1'b1, 4'b1101, 4'b1011, 1'b0, 1'b0, 0);

    // Corrupted snapshot during CAPTURE
    run_req("r0110_forced", 4'b0110, 1'b0, 4'b0110, 4'b0000, EXP_FORCED_ERR, 1'b1, 0);

    // DONE stall with rsp_ready low for 5 cycles
    run_req("r0011_stall", 4'b0011, 1'b1, 4'b1100, 4'b0011, 1'b0, 1'b0, 5);

    // Reset after two LOAD cycles
    req_word  = 4'b1111;
    req_dir   = 1'b0;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_sr_outs", 32'({sr_reset, sr_shift, sr_data_in}), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    chk("midrst_release_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      tick();
      chk($sformatf("midrst_no_rsp%0d", i), 32'({rsp_valid, sr_reset, sr_shift}), 32'd0);
    end

    // Continuous req_valid across two requests with rsp_ready tied high
    rsp_ready = 1'b1;
    req_word  = 4'b0101;
    req_dir   = 1'b0;
    req_valid = 1'b1;
    n_acc = 0;
    n_rsp = 0;
    for (int cyc = 1; cyc <= 40 && n_rsp < 2; cyc++) begin
      acc_now = req_ready && req_valid;
      tick();
      if (acc_now && n_acc < 2) begin
        acc_t[n_acc] = cyc;
        n_acc++;
        if (n_acc == 1) begin
          req_word = 4'b1100;
          req_dir  = 1'b1;
        end
      end
      if (rsp_valid && n_rsp < 2) begin
        rsp_t[n_rsp] = cyc;
        rsp_w[n_rsp] = rsp_word;
        n_rsp++;
      end
    end
    req_valid = 1'b0;
    chk("b2b_rsp_count", 32'(n_rsp), 32'd2);
    chk("b2b_acc_count", 32'(n_acc), 32'd2);
    if (n_rsp == 2 && n_acc == 2) begin
      chk("b2b_rsp0_word", 32'(rsp_w[0]), 32'(4'b0101));
      chk("b2b_rsp1_word", 32'(rsp_w[1]), 32'(4'b1100));
      chk("b2b_rsp0_latency", 32'(rsp_t[0] - acc_t[0]), 32'd6);
      chk("b2b_rsp1_latency", 32'(rsp_t[1] - acc_t[1]), 32'd6);
      chk("b2b_accept_after_rsp", 32'(acc_t[1] > rsp_t[0]), 32'd1);
    end
    tick();
    rsp_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
